// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The master requests operations; the slave reports status and results.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, cout, ovf, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, cout, ovf, zero
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell reused LSB first,
// WIDTH cycles per operation, results published only on completion.
module add_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic cout,
    output logic s
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_add_ctrl_if.slave    ctrl_if
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             op_q, op_d;
    logic             c_q, c_d;
    logic [WIDTH-2:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             accept;
    logic             last;
    logic             fa_co;
    logic             fa_s;
    logic [WIDTH-1:0] acc_nx;

    // Subtract is a + ~b + 1: invert the b bit, carry seeded from op.
    add_bit u_add_bit (
        .a    (a_q[0]),
        .b    (b_q[0] ^ op_q),
        .cin  (c_q),
        .cout (fa_co),
        .s    (fa_s)
    );

    assign accept = ctrl_if.start && (state_q != RUN);
    assign last   = (cnt_q == CW'(WIDTH - 1));
    assign acc_nx = {fa_s, acc_q};

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: start is ignored while running.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ctrl_if.start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = ctrl_if.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: latch on accept, shift one bit per RUN cycle.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        c_d    = c_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (accept) begin
            a_d   = ctrl_if.a;
            b_d   = ctrl_if.b;
            op_d  = ctrl_if.op;
            c_d   = ctrl_if.op;
            cnt_d = '0;
        end else if (state_q == RUN) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            c_d   = fa_co;
            acc_d = acc_nx[WIDTH-1:1];
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                res_d  = acc_nx;
                cout_d = fa_co;
                ovf_d  = c_q ^ fa_co;
                zero_d = ~|acc_nx;
            end
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= 1'b0;
            c_q    <= 1'b0;
            acc_q  <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            c_q    <= c_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign ctrl_if.busy   = (state_q == RUN);
    assign ctrl_if.done   = (state_q == DONE);
    assign ctrl_if.result = res_q;
    assign ctrl_if.cout   = cout_q;
    assign ctrl_if.ovf    = ovf_q;
    assign ctrl_if.zero   = zero_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH = 8.
// Inputs change on the falling edge; outputs are sampled 1 after rising edges.
module tb_serial_add_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    serial_add_ctrl_if #(.WIDTH(8)) bus ();

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation and count rising edges until done (-1 on timeout).
    task automatic do_op(input logic op, input logic [7:0] a,
                         input logic [7:0] b, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.op    = ~op;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op = 1'b0;
        bus.a = 8'h00;
        bus.b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.result, bus.cout, bus.ovf, bus.zero}
            !== 12'h000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want all zero",
                {bus.busy, bus.done, bus.result, bus.cout, bus.ovf, bus.zero});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        int lat;
        do_op(1'b0, 8'h35, 8'h4A, lat);
        n_cmp++;
        if (lat !== 8) begin
            n_err++;
            $display("FAIL add_latency: got %0d want 8", lat);
        end
        n_cmp++;
        if ({bus.result, bus.cout, bus.ovf, bus.zero} !== {8'h7F, 3'b000}) begin
            n_err++;
            $display("FAIL add_35_4A: got %h c%b v%b z%b want 7f c0 v0 z0",
                bus.result, bus.cout, bus.ovf, bus.zero);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_in_done: got %b want 0", bus.busy);
        end
        do_op(1'b0, 8'hFF, 8'h01, lat);
        n_cmp++;
        if (lat !== 8 ||
            {bus.result, bus.cout, bus.ovf, bus.zero} !== {8'h00, 3'b101}) begin
            n_err++;
            $display("FAIL add_FF_01: lat %0d got %h c%b v%b z%b want 8 00 c1 v0 z1",
                lat, bus.result, bus.cout, bus.ovf, bus.zero);
        end
        do_op(1'b0, 8'h7F, 8'h01, lat);
        n_cmp++;
        if (lat !== 8 ||
            {bus.result, bus.cout, bus.ovf, bus.zero} !== {8'h80, 3'b010}) begin
            n_err++;
            $display("FAIL add_7F_01: lat %0d got %h c%b v%b z%b want 8 80 c0 v1 z0",
                lat, bus.result, bus.cout, bus.ovf, bus.zero);
        end
    endtask

    task automatic test_sub();
        int lat;
        do_op(1'b1, 8'h10, 8'h20, lat);
        n_cmp++;
        if (lat !== 8 ||
            {bus.result, bus.cout, bus.ovf, bus.zero} !== {8'hF0, 3'b000}) begin
            n_err++;
            $display("FAIL sub_10_20: lat %0d got %h c%b v%b z%b want 8 f0 c0 v0 z0",
                lat, bus.result, bus.cout, bus.ovf, bus.zero);
        end
        do_op(1'b1, 8'h80, 8'h01, lat);
        n_cmp++;
        if (lat !== 8 ||
            {bus.result, bus.cout, bus.ovf, bus.zero} !== {8'h7F, 3'b110}) begin
            n_err++;
            $display("FAIL sub_80_01: lat %0d got %h c%b v%b z%b want 8 7f c1 v1 z0",
                lat, bus.result, bus.cout, bus.ovf, bus.zero);
        end
        do_op(1'b1, 8'h5A, 8'h5A, lat);
        n_cmp++;
        if (lat !== 8 ||
            {bus.result, bus.cout, bus.ovf, bus.zero} !== {8'h00, 3'b101}) begin
            n_err++;
            $display("FAIL sub_5A_5A: lat %0d got %h c%b v%b z%b want 8 00 c1 v0 z1",
                lat, bus.result, bus.cout, bus.ovf, bus.zero);
        end
    endtask

    task automatic test_ignore_start();
        logic [20:0] dmask;
        logic [7:0]  res8;
        dmask = '0;
        res8 = 8'hXX;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 1'b0;
        bus.a = 8'h35;
        bus.b = 8'h4A;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = 8'h01;
        bus.b = 8'h02;
        for (int n = 1; n <= 20; n++) begin
            if (n == 3) begin
                @(negedge clk);
                bus.start = 1'b1;
                bus.op = 1'b1;
                bus.a = 8'hC3;
                bus.b = 8'h11;
            end
            @(posedge clk);
            #1;
            if (n == 3) bus.start = 1'b0;
            dmask[n] = bus.done;
            if (n == 8) res8 = bus.result;
        end
        n_cmp++;
        if (dmask !== 21'h000100) begin
            n_err++;
            $display("FAIL ignore_done_pulses: got %b want only edge 8", dmask);
        end
        n_cmp++;
        if (res8 !== 8'h7F || bus.result !== 8'h7F) begin
            n_err++;
            $display("FAIL ignore_result: got %h/%h want 7f", res8, bus.result);
        end
    endtask

    task automatic test_back_to_back();
        logic [20:0] dmask;
        logic [20:0] bmask;
        logic [20:0] bexp;
        logic [7:0]  r8;
        logic [7:0]  r17;
        logic        z17;
        logic        c17;
        dmask = '0;
        bmask = '0;
        bexp = '0;
        for (int n = 1; n <= 7; n++) bexp[n] = 1'b1;
        for (int n = 9; n <= 16; n++) bexp[n] = 1'b1;
        r8 = 8'hXX;
        r17 = 8'hXX;
        z17 = 1'bx;
        c17 = 1'bx;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 1'b0;
        bus.a = 8'h35;
        bus.b = 8'h4A;
        @(posedge clk);
        #1;
        bus.a = 8'hFF;
        bus.b = 8'h01;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (n == 9) begin
                bus.start = 1'b0;
                bus.a = 8'h00;
                bus.b = 8'h00;
            end
            dmask[n] = bus.done;
            bmask[n] = bus.busy;
            if (n == 8) r8 = bus.result;
            if (n == 17) begin
                r17 = bus.result;
                z17 = bus.zero;
                c17 = bus.cout;
            end
        end
        n_cmp++;
        if (dmask !== 21'h020100) begin
            n_err++;
            $display("FAIL b2b_done: got %b want edges 8 and 17", dmask);
        end
        n_cmp++;
        if (bmask !== bexp) begin
            n_err++;
            $display("FAIL b2b_busy: got %b want %b", bmask, bexp);
        end
        n_cmp++;
        if (r8 !== 8'h7F || r17 !== 8'h00 || z17 !== 1'b1 || c17 !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_results: got %h %h z%b c%b want 7f 00 z1 c1",
                r8, r17, z17, c17);
        end
    endtask

    task automatic test_reset_abort();
        int          lat;
        logic [12:0] dmask;
        dmask = '0;
        do_op(1'b0, 8'h20, 8'h03, lat);
        n_cmp++;
        if (lat !== 8 || {bus.result, bus.cout, bus.ovf, bus.zero} !== {8'h23, 3'b000}) begin
            n_err++;
            $display("FAIL pre_abort_add: lat %0d got %h want 8 23", lat, bus.result);
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 1'b1;
        bus.a = 8'h00;
        bus.b = 8'h01;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.result, bus.cout, bus.ovf, bus.zero}
            !== 12'h000) begin
            n_err++;
            $display("FAIL abort_outputs: got %b want all zero",
                {bus.busy, bus.done, bus.result, bus.cout, bus.ovf, bus.zero});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            dmask[n] = bus.done | bus.busy;
        end
        n_cmp++;
        if (dmask !== '0) begin
            n_err++;
            $display("FAIL abort_no_done: got %b want 0", dmask);
        end
        do_op(1'b0, 8'h12, 8'h34, lat);
        n_cmp++;
        if (lat !== 8 || {bus.result, bus.cout, bus.ovf, bus.zero} !== {8'h46, 3'b000}) begin
            n_err++;
            $display("FAIL post_abort_add: lat %0d got %h want 8 46", lat, bus.result);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_add();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
